// File: rtl/an_encoder_seq.sv
// an_encoder_seq: sequential AN-code encoder, codeword = (A*N) ^ errmask via shift-and-add
module an_encoder_seq #(
  parameter int A  = 13,
  parameter int DW = 8,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [CW-1:0] in_errmask,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_code,
  output logic          out_inj
);
  localparam int cntw = $clog2(DW + 1);
  localparam logic [cntw-1:0] last = cntw'(DW - 1);
  if (CW < DW + $clog2(A)) begin : g_cw_check
    $error("an_encoder_seq: CW too small to hold A*N without overflow");
  end
  typedef enum logic [1:0] {idle, calc, done} state_t;
  state_t          state;
  logic [DW-1:0]   data;
  logic [CW-1:0]   mask;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   addend;
  logic [CW-1:0]   sum;
  logic [cntw-1:0] cnt;
  assign in_ready = rst_n && (state == idle);
  // partial sum for the current data bit; data is shifted so bit 0 is always the bit under test
  always_comb sum = acc + (data[0] ? addend : '0);
  // control FSM plus datapath registers; every data bit costs one clock, so latency is fixed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= idle;
      data      <= '0;
      mask      <= '0;
      acc       <= '0;
      addend    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_inj   <= 1'b0;
    end else begin
      case (state)
        idle: if (in_valid) begin
          data   <= in_data;
          mask   <= in_errmask;
          acc    <= '0;
          addend <= CW'(A);
          cnt    <= '0;
          state  <= calc;
        end
        calc: begin
          acc    <= sum;
          addend <= addend << 1;
          data   <= data >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == last) begin
            state     <= done;
            out_valid <= 1'b1;
            out_code  <= sum ^ mask;
            out_inj   <= |mask;
          end
        end
        done: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= idle;
        end
        default: state <= idle;
      endcase
    end
  end
endmodule

// File: tb/tb_an_encoder_seq.sv
// tb_an_encoder_seq: directed self-checking bench for an_encoder_seq
module tb_an_encoder_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [11:0] in_errmask = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_code;
  logic        out_inj;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];
  int code_q[$];

  an_encoder_seq #(.A(13), .DW(8), .CW(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_errmask(in_errmask), .out_valid(out_valid),
    .out_ready(out_ready), .out_code(out_code), .out_inj(out_inj)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    if (rst_n && out_valid && out_ready) code_q.push_back(int'(out_code));
  end

  // offer one word for a single edge; caller ensures in_ready is high
  task automatic send(input logic [7:0] d, input logic [11:0] m);
    in_data = d;
    in_errmask = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // count edges until out_valid appears (bounded)
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_code !== 12'd0) begin errors++; $display("FAIL reset_out_code got %0d want 0", out_code); end
    checks++; if (out_inj !== 1'b0) begin errors++; $display("FAIL reset_out_inj got %0b want 0", out_inj); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    send(8'd252, 12'h000);
    wait_out(lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL t1_latency got %0d want 8", lat); end
    checks++; if (out_code !== 12'd3276) begin errors++; $display("FAIL t1_code got %0d want 3276", out_code); end
    checks++; if (out_inj !== 1'b0) begin errors++; $display("FAIL t1_inj got %0b want 0", out_inj); end
    release_out();
  endtask

  task automatic test_errmask();
    logic [11:0] masks[4] = '{12'h001, 12'h002, 12'h100, 12'h200};
    int exp[4] = '{3277, 3278, 3532, 3788};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(8'd252, masks[i]);
      wait_out(lat);
      checks++; if (out_code !== 12'(exp[i])) begin errors++; $display("FAIL t2_code[%0d] got %0d want %0d", i, out_code, exp[i]); end
      checks++; if (out_inj !== 1'b1) begin errors++; $display("FAIL t2_inj[%0d] got %0b want 1", i, out_inj); end
      release_out();
    end
  endtask

  task automatic test_values();
    logic [7:0] ns[4] = '{8'd0, 8'd255, 8'd1, 8'd100};
    int exp[4] = '{0, 3315, 13, 1300};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(ns[i], 12'h000);
      wait_out(lat);
      checks++; if (out_code !== 12'(exp[i])) begin errors++; $display("FAIL t3_code[%0d] got %0d want %0d", i, out_code, exp[i]); end
      checks++; if ((int'(out_code) % 13) != 0) begin errors++; $display("FAIL t3_mod13[%0d] got %0d want 0", i, int'(out_code) % 13); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(8'd5, 12'h000);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_data = 8'd9; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_code !== 12'd65 || out_valid !== 1'b1) begin errors++; $display("FAIL t4_hold[%0d] got code %0d valid %0b want 65 1", i, out_code, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t4_in_ready[%0d] got %0b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_drop got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t4_ready got %0b want 1", in_ready); end
    checks++; if (out_code !== 12'd65) begin errors++; $display("FAIL t4_code_after got %0d want 65", out_code); end
  endtask

  task automatic test_reset_midcalc();
    int lat;
    send(8'd7, 12'h005);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_valid got %0b want 0", out_valid); end
    checks++; if (out_code !== 12'd0) begin errors++; $display("FAIL t5_code got %0d want 0", out_code); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t5_in_ready got %0b want 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t5_ready_after got %0b want 1", in_ready); end
    send(8'd2, 12'h000);
    wait_out(lat);
    checks++; if (out_code !== 12'd26 || lat != 8) begin errors++; $display("FAIL t5_recover got code %0d lat %0d want 26 8", out_code, lat); end
    checks++; if (out_inj !== 1'b0) begin errors++; $display("FAIL t5_inj got %0b want 0", out_inj); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int n;
    acc_q.delete();
    code_q.delete();
    out_ready = 1'b1;
    in_data = 8'd1;
    in_errmask = 12'h000;
    in_valid = 1'b1;
    n = 0;
    while (acc_q.size() < 1 && n < 40) begin @(posedge clk); #1; n++; end
    in_data = 8'd2;
    n = 0;
    while (acc_q.size() < 2 && n < 40) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    n = 0;
    while (code_q.size() < 2 && n < 40) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    checks++;
    if (acc_q.size() != 2 || code_q.size() != 2) begin
      errors++; $display("FAIL t6_count got accepts %0d codes %0d want 2 2", acc_q.size(), code_q.size());
    end else begin
      if (code_q[0] != 13) begin errors++; $display("FAIL t6_code0 got %0d want 13", code_q[0]); end
      checks++; if (code_q[1] != 26) begin errors++; $display("FAIL t6_code1 got %0d want 26", code_q[1]); end
      checks++; if (acc_q[1] - acc_q[0] != 10) begin errors++; $display("FAIL t6_spacing got %0d want 10", acc_q[1] - acc_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errmask();
    test_values();
    test_backpressure();
    test_reset_midcalc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
